flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_unit_pkg.sv | 18 +
 rtl/flag_unit_if.sv | 26 ++
 rtl/cond_eval.sv | 22 ++
 rtl/flag_unit.sv | 45 ++++
 tb/tb_flag_unit.sv | 89 ++++++++
 5 files changed

// File: rtl/flag_unit_pkg.sv
// flag_unit_pkg: shared CPU constants for ALU opcodes and branch conditions
package flag_unit_pkg;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;
  localparam logic [2:0] C_NEQ    = 3'b000;
  localparam logic [2:0] C_EQ     = 3'b001;
  localparam logic [2:0] C_GT     = 3'b010;
  localparam logic [2:0] C_LT     = 3'b011;
  localparam logic [2:0] C_GTE    = 3'b100;
  localparam logic [2:0] C_LTE    = 3'b101;
  localparam logic [2:0] C_OVFL   = 3'b110;
  localparam logic [2:0] C_UNCOND = 3'b111;
  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction
endpackage

// File: rtl/flag_unit_if.sv
// flag_unit_if: EX-stage inputs and flag/branch/EX-MEM outputs of the flag unit
interface flag_unit_if;
  logic       valid_in;
  logic       stall;
  logic       flush;
  logic [1:0] Opcode;
  logic       flag_we;
  logic [3:0] ALU_Out;
  logic       Ovfl;
  logic       br_valid;
  logic [2:0] cond;
  logic       Z;
  logic       V;
  logic       N;
  logic       br_taken;
  logic       mem_valid;
  logic [3:0] mem_result;
  modport master (
    output valid_in, stall, flush, Opcode, flag_we, ALU_Out, Ovfl, br_valid, cond,
    input  Z, V, N, br_taken, mem_valid, mem_result
  );
  modport slave (
    input  valid_in, stall, flush, Opcode, flag_we, ALU_Out, Ovfl, br_valid, cond,
    output Z, V, N, br_taken, mem_valid, mem_result
  );
endinterface

// File: rtl/cond_eval.sv
// cond_eval: combinational branch-condition decode from Z/V/N flags
module cond_eval
  import flag_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       V,
  input  logic       N,
  output logic       taken
);
  // decode the condition code against the supplied flags
  always_comb begin
    taken = cond == C_NEQ  ? ~Z :
            cond == C_EQ   ? Z :
            cond == C_GT   ? ~Z & ~N :
            cond == C_LT   ? N :
            cond == C_GTE  ? Z | (~Z & ~N) :
            cond == C_LTE  ? N | Z :
            cond == C_OVFL ? V :
            cond == C_UNCOND;
  end
endmodule

// File: rtl/flag_unit.sv
// flag_unit: Z/V/N flag register, bypassed branch resolution and EX/MEM register
module flag_unit
  import flag_unit_pkg::*;
(
  input logic         clk,
  input logic         rst,
  flag_unit_if.slave  bus
);
  logic advance, hold, wr_z, wr_vn, z_b, v_b, n_b, taken;
  // arithmetic ops write all flags, logic ops only Z; branch sees the new values
  always_comb begin
    advance = bus.valid_in & ~bus.stall & ~bus.flush;
    hold    = bus.stall & ~bus.flush;
    wr_z    = advance & bus.flag_we;
    wr_vn   = wr_z & is_arith(bus.Opcode);
    z_b     = wr_z ? (bus.ALU_Out == 4'b0000) : bus.Z;
    v_b     = wr_vn ? bus.Ovfl : bus.V;
    n_b     = wr_vn ? bus.ALU_Out[3] : bus.N;
  end
  cond_eval u_cond (
    .cond  (bus.cond),
    .Z     (z_b),
    .V     (v_b),
    .N     (n_b),
    .taken (taken)
  );
  // all architectural and pipeline state; flags only move when the bypass says so
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Z          <= 1'b0;
      bus.V          <= 1'b0;
      bus.N          <= 1'b0;
      bus.br_taken   <= 1'b0;
      bus.mem_valid  <= 1'b0;
      bus.mem_result <= 4'b0000;
    end else begin
      bus.Z          <= z_b;
      bus.V          <= v_b;
      bus.N          <= n_b;
      bus.br_taken   <= advance & bus.br_valid & taken;
      bus.mem_valid  <= advance | (hold & bus.mem_valid);
      bus.mem_result <= advance ? bus.ALU_Out : bus.mem_result;
    end
  end
endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: table-driven scoreboard bench for flag_unit
module tb_flag_unit;
  typedef struct packed {
    logic       rst, vi, st, fl;
    logic [1:0] op;
    logic       we;
    logic [3:0] alu;
    logic       ov, bv;
    logic [2:0] cond;
    logic [8:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   applied = 0;
  int   errors  = 0;
  logic [8:0] exp_q[$];
  vec_t vecs[$];
  flag_unit_if bus();
  flag_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic r, vi, st, fl, input logic [1:0] op, input logic we,
                              input logic [3:0] alu, input logic ov, bv, input logic [2:0] c,
                              input logic z, v, n, bt, mv, input logic [3:0] mr);
    vec_t t;
    t = '{rst:r, vi:vi, st:st, fl:fl, op:op, we:we, alu:alu, ov:ov, bv:bv, cond:c,
          exp:{z, v, n, bt, mv, mr}};
    return t;
  endfunction
  task automatic apply(input vec_t t, input string name);
    logic [8:0] got, want;
    @(negedge clk);
    rst = t.rst;
    bus.valid_in = t.vi;
    bus.stall = t.st;
    bus.flush = t.fl;
    bus.Opcode = t.op;
    bus.flag_we = t.we;
    bus.ALU_Out = t.alu;
    bus.Ovfl = t.ov;
    bus.br_valid = t.bv;
    bus.cond = t.cond;
    exp_q.push_back(t.exp);
    @(posedge clk);
    #1;
    got  = {bus.Z, bus.V, bus.N, bus.br_taken, bus.mem_valid, bus.mem_result};
    want = exp_q.pop_front();
    applied++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got ZVN=%b br=%b mv=%b mr=%h, want ZVN=%b br=%b mv=%b mr=%h",
               name, got[8:6], got[5], got[4], got[3:0], want[8:6], want[5], want[4], want[3:0]);
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.valid_in = 0; bus.stall = 0; bus.flush = 0; bus.Opcode = 0; bus.flag_we = 0;
    bus.ALU_Out = 0; bus.Ovfl = 0; bus.br_valid = 0; bus.cond = 0;
    //                 rst vi st fl op     we alu      ov bv cond     Z  V  N  bt mv mr
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 0, 4'h0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b00, 1, 4'h0, 0, 0, 3'b000, 1, 0, 0, 0, 1, 4'h0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 1, 4'hA, 1, 1, 3'b011, 0, 1, 1, 1, 1, 4'hA));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 0, 4'h0, 0, 0, 3'b000, 0, 1, 1, 0, 0, 4'hA));
    vecs.push_back(mk(0, 1, 0, 0, 2'b11, 1, 4'h0, 0, 1, 3'b010, 1, 1, 1, 0, 1, 4'h0));
    vecs.push_back(mk(0, 1, 1, 0, 2'b00, 1, 4'h5, 0, 1, 3'b111, 1, 1, 1, 0, 1, 4'h0));
    vecs.push_back(mk(0, 1, 1, 1, 2'b00, 1, 4'h5, 0, 1, 3'b111, 1, 1, 1, 0, 0, 4'h0));
    vecs.push_back(mk(0, 1, 0, 1, 2'b00, 1, 4'h3, 0, 1, 3'b111, 1, 1, 1, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 1, 4'h0, 0, 1, 3'b111, 1, 1, 1, 0, 0, 4'h0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b00, 1, 4'h3, 0, 0, 3'b000, 0, 0, 0, 0, 1, 4'h3));
    for (int c = 0; c < 8; c++)
      vecs.push_back(mk(0, 1, 0, 0, 2'b01, 0, 4'h7, 1, 1, 3'(c), 0, 0, 0,
                        (c == 0 || c == 2 || c == 4 || c == 7), 1, 4'h7));
    vecs.push_back(mk(0, 1, 0, 0, 2'b10, 1, 4'h8, 1, 0, 3'b000, 0, 0, 0, 0, 1, 4'h8));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 0, 4'h0, 0, 1, 3'b001, 0, 0, 0, 0, 1, 4'h0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 1, 4'hF, 1, 1, 3'b110, 0, 1, 1, 1, 1, 4'hF));
    vecs.push_back(mk(1, 1, 1, 1, 2'b00, 1, 4'h9, 1, 1, 3'b111, 0, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 0, 4'h0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b00, 1, 4'h8, 1, 1, 3'b101, 0, 1, 1, 1, 1, 4'h8));
    vecs.push_back(mk(0, 1, 1, 0, 2'b00, 1, 4'h0, 0, 1, 3'b111, 0, 1, 1, 0, 1, 4'h8));
    vecs.push_back(mk(0, 1, 0, 0, 2'b00, 0, 4'h0, 0, 1, 3'b100, 0, 1, 1, 0, 1, 4'h0));
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));
    for (int k = 0; k < 3; k++)
      apply(mk(0, 1, 1, 0, 2'b00, 1, 4'h0, 0, 1, 3'b001, 0, 1, 1, 0, 1, 4'h0),
            $sformatf("long_stall%0d", k));
    apply(mk(0, 1, 0, 0, 2'b00, 1, 4'h0, 0, 1, 3'b001, 1, 0, 0, 1, 1, 4'h0), "stall_release");
    apply(mk(0, 0, 0, 0, 2'b00, 0, 4'h0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 4'h0), "pulse_end");
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule
